alu_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit ALU slice (AND/OR/XOR/ADD, built from `and8b`, `or8b`, `xor8b`, `adder8b` and `mux8_4to1b`) among four requesters. It runs a fixed three-state sequence per operation:
- grant and latch operands;
- execute and register the result;
- return to idle.

The result goes back to the winning requester with a one-cycle valid pulse. It sits between the requester front-ends and the shared ALU and replaces per-requester ALU copies.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu8.sv | 83 ++++++++
 rtl/alu_rr_arbiter.sv | 98 +++++++++
 tb/tb_alu_rr_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the round-robin ALU arbiter.
// Holds the opcode encodings, FSM state type and a one-hot helper.
package alu_pkg;

   localparam int N_REQ = 4;
   localparam int WIDTH = 8;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_ADD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU slice: AND/OR/XOR/ADD primitives feeding a 4:1 mux.
// Carry-out is only reported for the ADD opcode.
module and8b (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic [7:0] y_o
);
   assign y_o = a_i & b_i;
endmodule

module or8b (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic [7:0] y_o
);
   assign y_o = a_i | b_i;
endmodule

module xor8b (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic [7:0] y_o
);
   assign y_o = a_i ^ b_i;
endmodule

module adder8b (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       cin_i,
   output logic [7:0] s_o,
   output logic       cout_o
);
   assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {8'd0, cin_i};
endmodule

module mux8_4to1b (
   input  logic [7:0] d0_i,
   input  logic [7:0] d1_i,
   input  logic [7:0] d2_i,
   input  logic [7:0] d3_i,
   input  logic [1:0] sel_i,
   output logic [7:0] y_o
);
   // NOTE: every select value is covered, so no latch can be inferred here.
   always_comb begin
      unique case (sel_i)
         2'b00:   y_o = d0_i;
         2'b01:   y_o = d1_i;
         2'b10:   y_o = d2_i;
         default: y_o = d3_i;
      endcase
   end
endmodule

module alu8
   import alu_pkg::*;
(
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] y_o,
   output logic             cout_o
);
   logic [WIDTH-1:0] and_y, or_y, xor_y, sum_y;
   logic             add_c;

   and8b   u_and (.a_i(a_i), .b_i(b_i), .y_o(and_y));
   or8b    u_or  (.a_i(a_i), .b_i(b_i), .y_o(or_y));
   xor8b   u_xor (.a_i(a_i), .b_i(b_i), .y_o(xor_y));
   adder8b u_add (.a_i(a_i), .b_i(b_i), .cin_i(1'b0), .s_o(sum_y), .cout_o(add_c));

   mux8_4to1b u_mux (
      .d0_i (and_y),
      .d1_i (or_y),
      .d2_i (xor_y),
      .d3_i (sum_y),
      .sel_i(op_i),
      .y_o  (y_o)
   );

   assign cout_o = add_c & (op_i == OP_ADD);
endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU slice among four requesters.
// Each operation runs IDLE -> EXEC -> RESP with one-cycle grant and response pulses.
module alu_rr_arbiter
   import alu_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [2*N_REQ-1:0]       op,
   input  logic [WIDTH*N_REQ-1:0]   a,
   input  logic [WIDTH*N_REQ-1:0]   b,
   output logic [N_REQ-1:0]         gnt,
   output logic [N_REQ-1:0]         rsp_valid,
   output logic [WIDTH-1:0]         rsp_data,
   output logic                     rsp_cout,
   output logic                     busy
);
   arb_state_t       state_q;
   logic [1:0]       ptr_q, win_q, win_d;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [N_REQ-1:0] gnt_q, rsp_valid_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic             rsp_cout_q;
   logic [WIDTH-1:0] alu_y;
   logic             alu_cout;

   // First requesting index found when scanning upward from ptr_q, wrapping mod 4.
   always_comb begin
      logic       found;
      logic [1:0] idx;
      win_d = ptr_q;
      found = 1'b0;
      idx   = ptr_q;
      for (int k = 0; k < N_REQ; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && req[idx]) begin
            win_d = idx;
            found = 1'b1;
         end
      end
   end

   alu8 u_alu (
      .op_i  (op_q),
      .a_i   (a_q),
      .b_i   (b_q),
      .y_o   (alu_y),
      .cout_o(alu_cout)
   );

   // NOTE: sequential state uses non-blocking assignments only, and the operand
   // latches are reset too so no X ever reaches the ALU output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         win_q       <= '0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_cout_q  <= 1'b0;
      end else begin
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         unique case (state_q)
            IDLE: begin
               if (|req) begin
                  win_q   <= win_d;
                  op_q    <= op[{win_d, 1'b0} +: 2];
                  a_q     <= a[{win_d, 3'b000} +: WIDTH];
                  b_q     <= b[{win_d, 3'b000} +: WIDTH];
                  gnt_q   <= onehot(win_d);
                  ptr_q   <= win_d + 2'd1;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               rsp_data_q  <= alu_y;
               rsp_cout_q  <= alu_cout;
               rsp_valid_q <= onehot(win_q);
               state_q     <= RESP;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_cout  = rsp_cout_q;
   assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level round-robin/ALU model.
module tb_alu_rr_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [7:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  gnt;
   logic [3:0]  rsp_valid;
   logic [7:0]  rsp_data;
   logic        rsp_cout;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int m_ptr  = 0;

   alu_rr_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .op       (op),
      .a        (a),
      .b        (b),
      .gnt      (gnt),
      .rsp_valid(rsp_valid),
      .rsp_data (rsp_data),
      .rsp_cout (rsp_cout),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU from the opcode table: 9-bit sum gives the carry.
   function automatic logic [8:0] ref_alu(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
      case (o)
         2'b00:   return {1'b0, x & y};
         2'b01:   return {1'b0, x | y};
         2'b10:   return {1'b0, x ^ y};
         default: return 9'(int'(x) + int'(y));
      endcase
   endfunction

   // Reference winner: first set bit scanning ptr, ptr+1, ... mod 4.
   function automatic int ref_pick(input logic [3:0] mask, input int p);
      for (int k = 0; k < 4; k++) begin
         if (mask[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full operation from IDLE with the current req/op/a/b; checks every cycle.
   task automatic run_op(input bit drop_req, input string tag, output int w);
      logic [8:0] exp;
      logic [3:0] exp_oh;
      w      = ref_pick(req, m_ptr);
      exp    = ref_alu(op[2*w +: 2], a[8*w +: 8], b[8*w +: 8]);
      exp_oh = 4'b0001 << w;
      step();
      checks++;
      if (gnt !== exp_oh || rsp_valid !== 4'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s grant: gnt=%b rsp_valid=%b busy=%b, want gnt=%b rsp_valid=0000 busy=1",
                  tag, gnt, rsp_valid, busy, exp_oh);
      end
      if (drop_req) req[w] = 1'b0;
      m_ptr = (w + 1) % 4;
      step();
      checks++;
      if (gnt !== 4'b0 || rsp_valid !== exp_oh || rsp_data !== exp[7:0] || rsp_cout !== exp[8] || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s resp: gnt=%b rsp_valid=%b data=%h cout=%b busy=%b, want gnt=0000 rsp_valid=%b data=%h cout=%b busy=1",
                  tag, gnt, rsp_valid, rsp_data, rsp_cout, busy, exp_oh, exp[7:0], exp[8]);
      end
      step();
      checks++;
      if (rsp_valid !== 4'b0 || busy !== 1'b0 || rsp_data !== exp[7:0] || rsp_cout !== exp[8]) begin
         errors++;
         $display("FAIL %s idle: rsp_valid=%b busy=%b data=%h cout=%b, want rsp_valid=0000 busy=0 data=%h cout=%b",
                  tag, rsp_valid, busy, rsp_data, rsp_cout, exp[7:0], exp[8]);
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0 || rsp_valid !== 4'b0 || rsp_data !== 8'h00 || rsp_cout !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: gnt=%b rsp_valid=%b data=%h cout=%b busy=%b, want all zero",
                  gnt, rsp_valid, rsp_data, rsp_cout, busy);
      end
      step();
      @(negedge clk);
      rst   = 1'b0;
      m_ptr = 0;
      step();
   endtask

   task automatic test_reset();
      req = '0; op = '0; a = '0; b = '0;
      apply_reset();
      step();
      checks++;
      if (gnt !== 4'b0 || rsp_valid !== 4'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: gnt=%b rsp_valid=%b busy=%b, want 0000 0000 0", gnt, rsp_valid, busy);
      end
   endtask

   task automatic test_add_carry();
      int w;
      req = 4'b0001; op = 8'h03; a = 32'h0000_00F0; b = 32'h0000_0020;
      run_op(1'b1, "add_carry", w);
   endtask

   task automatic test_round_robin();
      int w;
      apply_reset();
      req = 4'b1111; op = 8'hE4; a = 32'hCCCC_CCCC; b = 32'hAAAA_AAAA;
      for (int i = 0; i < 5; i++) begin
         run_op(1'b0, $sformatf("rr_%0d", i), w);
         checks++;
         if (w != i % 4) begin
            errors++;
            $display("FAIL rr_order_%0d: model winner=%0d, want %0d", i, w, i % 4);
         end
      end
      req = '0;
   endtask

   task automatic test_ptr_order();
      int w;
      apply_reset();
      req = 4'b0010; op = 8'hFF; a = 32'h0403_0201; b = 32'h1010_1010;
      run_op(1'b1, "ptr_g1", w);
      req = 4'b0011;
      run_op(1'b1, "ptr_first0", w);
      run_op(1'b1, "ptr_then1", w);
   endtask

   task automatic test_pulse_while_busy();
      req = 4'b0001; op = 8'h00; a = 32'h0000_0033; b = 32'h0000_000F;
      step();
      checks++;
      if (gnt !== 4'b0001 || busy !== 1'b1) begin
         errors++;
         $display("FAIL pulse_grant: gnt=%b busy=%b, want 0001 1", gnt, busy);
      end
      req = 4'b0100;
      step();
      req = 4'b0000;
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_data !== 8'h03) begin
         errors++;
         $display("FAIL pulse_resp: rsp_valid=%b data=%h, want 0001 03", rsp_valid, rsp_data);
      end
      m_ptr = 1;
      step();
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (gnt !== 4'b0 || rsp_valid !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pulse_ignored_%0d: gnt=%b rsp_valid=%b busy=%b, want 0000 0000 0", i, gnt, rsp_valid, busy);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      int w;
      req = 4'b1000; op = 8'hC0; a = 32'h5500_0000; b = 32'h6600_0000;
      step();
      req = 4'b0000;
      #1 rst = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0 || rsp_valid !== 4'b0 || rsp_data !== 8'h00 || rsp_cout !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: gnt=%b rsp_valid=%b data=%h cout=%b busy=%b, want all zero",
                  gnt, rsp_valid, rsp_data, rsp_cout, busy);
      end
      @(negedge clk);
      rst   = 1'b0;
      m_ptr = 0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_rsp_%0d: rsp_valid=%b busy=%b, want 0000 0", i, rsp_valid, busy);
         end
      end
      req = 4'b0100; op = 8'h30; a = 32'h0099_0000; b = 32'h0077_0000;
      run_op(1'b1, "after_reset", w);
   endtask

   task automatic test_xor_hold();
      int w;
      req = 4'b0001; op = 8'h02; a = 32'h0000_00FF; b = 32'h0000_000F;
      run_op(1'b1, "xor", w);
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (rsp_data !== 8'hF0 || rsp_cout !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL xor_hold_%0d: data=%h cout=%b busy=%b, want F0 0 0", i, rsp_data, rsp_cout, busy);
         end
      end
   endtask

   task automatic test_random();
      int w;
      int age [4];
      for (int i = 0; i < 4; i++) age[i] = 0;
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < 4; i++) begin
            if (!req[i] && ($urandom_range(1, 0) == 1)) begin
               req[i]        = 1'b1;
               op[2*i +: 2]  = 2'($urandom_range(3, 0));
               a[8*i +: 8]   = 8'($urandom_range(255, 0));
               b[8*i +: 8]   = 8'($urandom_range(255, 0));
               age[i]        = 0;
            end
         end
         if (req == 4'b0) begin
            req[0] = 1'b1;
            age[0] = 0;
         end
         run_op(1'b1, $sformatf("rand_%0d", it), w);
         checks++;
         if (age[w] > 3) begin
            errors++;
            $display("FAIL rand_fairness_%0d: requester %0d waited %0d ops, want at most 3", it, w, age[w]);
         end
         for (int i = 0; i < 4; i++) begin
            if (req[i]) age[i]++;
         end
      end
      req = '0;
      step();
   endtask

   initial begin
      rst = 1'b1;
      req = '0; op = '0; a = '0; b = '0;
      test_reset();
      test_add_carry();
      test_round_robin();
      test_ptr_order();
      test_pulse_while_busy();
      test_reset_mid_op();
      test_xor_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
